// File: rtl/char_health_ctrl.sv
// Player hit-point controller: arbitrates damage and heal requests onto a single HP register,
// and sequences invulnerability frames, heal cooldown and death.
module char_health_ctrl #(
  parameter int IFRAMES       = 60,
  parameter int HEAL_COOLDOWN = 30,
  parameter int HP_MELEE      = 8,
  parameter int HP_ARCHER     = 6,
  parameter int HP_DEFAULT    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic [1:0] game_active,
  input  logic [1:0] char_class,
  input  logic       dmg_req,
  input  logic [3:0] dmg_amt,
  input  logic       heal_req,
  input  logic [3:0] heal_amt,
  output logic       dmg_ack,
  output logic       heal_ack,
  output logic [3:0] char_hp,
  output logic [3:0] max_hp,
  output logic       invuln,
  output logic       blink,
  output logic       dead
);

  localparam int IFW = $clog2(IFRAMES + 1);
  localparam int HCW = $clog2(HEAL_COOLDOWN + 1);
  localparam logic [IFW-1:0] IFRAMES_V  = IFW'(IFRAMES);
  localparam logic [HCW-1:0] HEAL_CD_V  = HCW'(HEAL_COOLDOWN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t         state_q, state_nx;
  logic [3:0]     hp_q, hp_nx;
  logic [3:0]     max_q, max_nx;
  logic [IFW-1:0] iframe_cnt, iframe_nx;
  logic [HCW-1:0] heal_cd, heal_cd_nx;
  logic           dack_q, dack_nx;
  logic           hack_q, hack_nx;
  logic [3:0]     class_hp;
  logic [4:0]     heal_sum;
  logic           dmg_take;
  logic           heal_take;

  always_comb begin
    case (char_class)
      2'd1:    class_hp = 4'(HP_MELEE);
      2'd2:    class_hp = 4'(HP_ARCHER);
      default: class_hp = 4'(HP_DEFAULT);
    endcase
  end

  // Five-bit sum so a large heal on a high HP value clamps to max instead of wrapping.
  assign heal_sum = {1'b0, hp_q} + {1'b0, heal_amt};

  always_comb begin
    state_nx   = state_q;
    hp_nx      = hp_q;
    max_nx     = max_q;
    iframe_nx  = iframe_cnt;
    heal_cd_nx = heal_cd;
    dack_nx    = 1'b0;
    hack_nx    = 1'b0;
    dmg_take   = 1'b0;
    heal_take  = 1'b0;

    if (game_start) begin
      max_nx     = class_hp;
      hp_nx      = class_hp;
      iframe_nx  = '0;
      heal_cd_nx = '0;
      state_nx   = ALIVE;
    end else if (game_active == 2'd1 && state_q != IDLE) begin
      if (frame_tick) begin
        if (iframe_cnt != '0) begin
          iframe_nx = iframe_cnt - IFW'(1);
          if (iframe_cnt == IFW'(1) && state_q == INVULN) state_nx = ALIVE;
        end
        if (heal_cd != '0) heal_cd_nx = heal_cd - HCW'(1);
      end

      // A held dmg_req still blocks heals in its post-ack cycle, so heals wait for it to drop.
      dmg_take  = dmg_req && !dack_q;
      heal_take = heal_req && !dmg_req && !hack_q && (state_q == DEAD || heal_cd == '0);

      if (dmg_take) begin
        dack_nx = 1'b1;
        if (state_q == ALIVE) begin
          if (dmg_amt >= hp_q) begin
            hp_nx    = 4'd0;
            state_nx = DEAD;
          end else begin
            hp_nx = hp_q - dmg_amt;
            if (dmg_amt != 4'd0) begin
              state_nx  = INVULN;
              iframe_nx = IFRAMES_V;
            end
          end
        end
      end else if (heal_take) begin
        hack_nx = 1'b1;
        if (state_q != DEAD && heal_amt != 4'd0) begin
          hp_nx      = (heal_sum > {1'b0, max_q}) ? max_q : heal_sum[3:0];
          heal_cd_nx = HEAL_CD_V;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hp_q       <= 4'd0;
      max_q      <= 4'd0;
      iframe_cnt <= '0;
      heal_cd    <= '0;
      dack_q     <= 1'b0;
      hack_q     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      hp_q       <= hp_nx;
      max_q      <= max_nx;
      iframe_cnt <= iframe_nx;
      heal_cd    <= heal_cd_nx;
      dack_q     <= dack_nx;
      hack_q     <= hack_nx;
    end
  end

  assign dmg_ack  = dack_q;
  assign heal_ack = hack_q;
  assign char_hp  = hp_q;
  assign max_hp   = max_q;
  assign invuln   = (state_q == INVULN);
  assign blink    = invuln & iframe_cnt[2];
  assign dead     = (state_q == DEAD);

endmodule

// File: tb/tb_char_health_ctrl.sv
// Directed bench for char_health_ctrl: table of one-cycle vectors plus hand-written
// multi-cycle sequences for i-frame expiry, heal cooldown and asynchronous reset.
module tb_char_health_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, game_start;
  logic [1:0] game_active, char_class;
  logic       dmg_req, heal_req;
  logic [3:0] dmg_amt, heal_amt;
  logic       dmg_ack, heal_ack, invuln, blink, dead;
  logic [3:0] char_hp, max_hp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  char_health_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
    .game_active(game_active), .char_class(char_class),
    .dmg_req(dmg_req), .dmg_amt(dmg_amt), .heal_req(heal_req), .heal_amt(heal_amt),
    .dmg_ack(dmg_ack), .heal_ack(heal_ack), .char_hp(char_hp), .max_hp(max_hp),
    .invuln(invuln), .blink(blink), .dead(dead)
  );

  typedef struct {
    logic       gs;
    logic [1:0] ga;
    logic [1:0] cls;
    logic       ft;
    logic       dr;
    logic [3:0] da;
    logic       hr;
    logic [3:0] ha;
    logic       e_dack;
    logic       e_hack;
    logic [3:0] e_hp;
    logic [3:0] e_max;
    logic       e_inv;
    logic       e_blink;
    logic       e_dead;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  function automatic vec_t mk(input logic gs, input logic [1:0] ga, input logic [1:0] cls,
                              input logic ft, input logic dr, input logic [3:0] da,
                              input logic hr, input logic [3:0] ha,
                              input logic e_dack, input logic e_hack, input logic [3:0] e_hp,
                              input logic [3:0] e_max, input logic e_inv, input logic e_blink,
                              input logic e_dead);
    vec_t v;
    v.gs = gs; v.ga = ga; v.cls = cls; v.ft = ft; v.dr = dr; v.da = da; v.hr = hr; v.ha = ha;
    v.e_dack = e_dack; v.e_hack = e_hack; v.e_hp = e_hp; v.e_max = e_max;
    v.e_inv = e_inv; v.e_blink = e_blink; v.e_dead = e_dead;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    game_start  = v.gs;
    game_active = v.ga;
    char_class  = v.cls;
    frame_tick  = v.ft;
    dmg_req     = v.dr;
    dmg_amt     = v.da;
    heal_req    = v.hr;
    heal_amt    = v.ha;
  endtask

  task automatic set_idle();
    game_start = 1'b0; game_active = 2'd1; frame_tick = 1'b0;
    dmg_req = 1'b0; dmg_amt = 4'd0; heal_req = 1'b0; heal_amt = 4'd0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("row%0d dmg_ack", i),  int'(dmg_ack),  int'(vecs[i].e_dack));
      check_output($sformatf("row%0d heal_ack", i), int'(heal_ack), int'(vecs[i].e_hack));
      check_output($sformatf("row%0d char_hp", i),  int'(char_hp),  int'(vecs[i].e_hp));
      check_output($sformatf("row%0d max_hp", i),   int'(max_hp),   int'(vecs[i].e_max));
      check_output($sformatf("row%0d invuln", i),   int'(invuln),   int'(vecs[i].e_inv));
      check_output($sformatf("row%0d blink", i),    int'(blink),    int'(vecs[i].e_blink));
      check_output($sformatf("row%0d dead", i),     int'(dead),     int'(vecs[i].e_dead));
    end
  endtask

  initial begin
    int a_end, b_end, c_end, d_end, e_end;
    int cnt;

    // Fields: gs ga cls ft dr da hr ha | dack hack hp max inv blink dead
    add(mk(0,1,0,0,1,3,0,0,  0,0,0,0,0,0,0));
    add(mk(1,1,1,0,1,3,0,0,  0,0,8,8,0,0,0));
    add(mk(0,1,1,0,1,3,0,0,  1,0,5,8,1,1,0));
    add(mk(0,1,1,0,1,3,0,0,  0,0,5,8,1,1,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,5,8,1,1,0));
    add(mk(0,1,1,0,1,2,0,0,  1,0,5,8,1,1,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,5,8,1,1,0));
    a_end = nvec - 1;
    add(mk(0,1,1,0,1,0,1,0,  1,0,5,8,0,0,0));
    add(mk(0,1,1,0,1,0,1,0,  0,0,5,8,0,0,0));
    add(mk(0,1,1,0,0,0,1,0,  0,1,5,8,0,0,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,5,8,0,0,0));
    add(mk(0,1,1,0,0,0,1,7,  0,1,8,8,0,0,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,8,8,0,0,0));
    add(mk(0,1,1,0,1,3,0,0,  1,0,5,8,1,1,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,5,8,1,1,0));
    b_end = nvec - 1;
    add(mk(0,1,1,0,1,5,0,0,  1,0,2,8,1,1,0));
    add(mk(0,1,1,0,0,0,0,0,  0,0,2,8,1,1,0));
    c_end = nvec - 1;
    add(mk(0,1,1,0,1,15,0,0, 1,0,0,8,0,0,1));
    add(mk(0,1,1,0,0,0,0,0,  0,0,0,8,0,0,1));
    add(mk(0,1,1,0,1,1,0,0,  1,0,0,8,0,0,1));
    add(mk(0,1,1,0,0,0,0,0,  0,0,0,8,0,0,1));
    add(mk(0,1,1,0,0,0,1,3,  0,1,0,8,0,0,1));
    add(mk(0,1,1,0,0,0,0,0,  0,0,0,8,0,0,1));
    add(mk(1,0,2,0,0,0,1,1,  0,0,6,6,0,0,0));
    add(mk(0,1,2,0,0,0,1,15, 0,1,6,6,0,0,0));
    add(mk(0,1,2,0,0,0,0,0,  0,0,6,6,0,0,0));
    d_end = nvec - 1;
    add(mk(0,1,2,0,1,1,0,0,  1,0,5,6,1,1,0));
    add(mk(0,1,2,0,0,0,0,0,  0,0,5,6,1,1,0));
    for (int i = 0; i < 4; i++) add(mk(0,2,2,1,1,1,0,0, 0,0,5,6,1,1,0));
    add(mk(0,1,2,0,1,1,0,0,  1,0,5,6,1,1,0));
    add(mk(0,1,2,1,0,0,0,0,  0,0,5,6,1,0,0));
    e_end = nvec - 1;

    rst = 1'b0;
    char_class = 2'd0;
    set_idle();
    game_active = 2'd0;
    step();
    step();
    check_output("reset char_hp", int'(char_hp), 0);
    check_output("reset max_hp", int'(max_hp), 0);
    check_output("reset acks", int'({dmg_ack, heal_ack}), 0);
    check_output("reset flags", int'({invuln, blink, dead}), 0);
    rst = 1'b1;

    run_rows(0, a_end);

    // I-frames from the damage hit run out on the 60th frame tick.
    set_idle();
    for (int k = 1; k <= 60; k++) begin
      frame_tick = 1'b1;
      step();
      cnt = 60 - k;
      check_output($sformatf("iframe tick%0d invuln", k), int'(invuln), (cnt != 0) ? 1 : 0);
      check_output($sformatf("iframe tick%0d blink", k), int'(blink),
                   (cnt != 0) ? ((cnt >> 2) & 1) : 0);
    end
    frame_tick = 1'b0;
    check_output("iframe end char_hp", int'(char_hp), 5);

    run_rows(a_end + 1, b_end);

    // Second heal is held through the 30-tick cooldown, then applied once.
    set_idle();
    heal_req = 1'b1;
    heal_amt = 4'd2;
    for (int k = 1; k <= 30; k++) begin
      frame_tick = 1'b1;
      step();
      check_output($sformatf("cooldown tick%0d heal_ack", k), int'(heal_ack), 0);
      frame_tick = 1'b0;
      step();
      check_output($sformatf("cooldown gap%0d heal_ack", k), int'(heal_ack), (k == 30) ? 1 : 0);
      check_output($sformatf("cooldown gap%0d char_hp", k), int'(char_hp), (k == 30) ? 7 : 5);
    end
    heal_req = 1'b0;
    step();
    check_output("after heal heal_ack", int'(heal_ack), 0);
    check_output("after heal char_hp", int'(char_hp), 7);
    check_output("after heal invuln", int'(invuln), 1);
    for (int k = 1; k <= 30; k++) begin
      frame_tick = 1'b1;
      step();
      check_output($sformatf("iframe rest%0d invuln", k), int'(invuln), (k < 30) ? 1 : 0);
    end
    frame_tick = 1'b0;

    run_rows(b_end + 1, c_end);

    set_idle();
    frame_tick = 1'b1;
    for (int k = 1; k <= 60; k++) step();
    frame_tick = 1'b0;
    check_output("hp2 alive invuln", int'(invuln), 0);
    check_output("hp2 alive char_hp", int'(char_hp), 2);

    run_rows(c_end + 1, d_end);
    run_rows(d_end + 1, e_end);

    // Asynchronous reset mid-INVULN clears everything without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check_output("async rst char_hp", int'(char_hp), 0);
    check_output("async rst max_hp", int'(max_hp), 0);
    check_output("async rst invuln", int'(invuln), 0);
    check_output("async rst blink", int'(blink), 0);
    check_output("async rst dead", int'(dead), 0);
    check_output("async rst acks", int'({dmg_ack, heal_ack}), 0);
    step();
    set_idle();
    dmg_req = 1'b1;
    dmg_amt = 4'd1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output($sformatf("post rst%0d dmg_ack", k), int'(dmg_ack), 0);
      check_output($sformatf("post rst%0d char_hp", k), int'(char_hp), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
